// File: rtl/gcd_pkg.sv
// Shared FSM state encoding and mode constants for the GCD unit.
package gcd_pkg;

    typedef logic [1:0] gcd_state_t;

    localparam gcd_state_t IDLE = 2'd0;
    localparam gcd_state_t CALC = 2'd1;
    localparam gcd_state_t DONE = 2'd2;

    localparam logic MODE_SUB = 1'b0;
    localparam logic MODE_BIN = 1'b1;

endpackage

// File: rtl/gcd_step.sv
// One combinational GCD iteration: subtractive Euclid or binary (Stein) step,
// plus the termination test and the final result for the current operands.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int K_W   = 5
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [K_W-1:0]   k_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [K_W-1:0]   k_o,
    output logic             term_o,
    output logic [WIDTH-1:0] result_o
);

    always_comb begin
        a_o      = a_i;
        b_o      = b_i;
        k_o      = k_i;
        term_o   = 1'b0;
        result_o = '0;
        if (mode_i == MODE_SUB) begin
            if (a_i == '0) begin
                term_o   = 1'b1;
                result_o = b_i;
            end else if ((b_i == '0) || (a_i == b_i)) begin
                term_o   = 1'b1;
                result_o = a_i;
            end else if (a_i > b_i) begin
                a_o = a_i - b_i;
            end else begin
                b_o = b_i - a_i;
            end
        end else begin
            // k only counts shared factors of two, so the final shift fits WIDTH.
            if (a_i == '0) begin
                term_o   = 1'b1;
                result_o = b_i << k_i;
            end else if ((b_i == '0) || (a_i == b_i)) begin
                term_o   = 1'b1;
                result_o = a_i << k_i;
            end else if (!a_i[0] && !b_i[0]) begin
                a_o = a_i >> 1;
                b_o = b_i >> 1;
                k_o = k_i + 1'b1;
            end else if (!a_i[0]) begin
                a_o = a_i >> 1;
            end else if (!b_i[0]) begin
                b_o = b_i >> 1;
            end else if (a_i > b_i) begin
                a_o = a_i - b_i;
            end else begin
                b_o = b_i - a_i;
            end
        end
    end

endmodule

// File: rtl/gcd_unit.sv
// Iterative GCD engine with valid/ready handshakes on both sides; one step per
// CALC cycle, result held in DONE until the consumer takes it.
module gcd_unit
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gcd_out,
    output logic [CNT_W-1:0] iter_out,
    output logic             busy
);

    localparam int K_W = $clog2(WIDTH) + 1;

    gcd_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;

    logic [WIDTH-1:0] step_a, step_b, step_result;
    logic [K_W-1:0]   step_k;
    logic             step_term;

    gcd_step #(
        .WIDTH (WIDTH),
        .K_W   (K_W)
    ) u_step (
        .a_i      (a_q),
        .b_i      (b_q),
        .k_i      (k_q),
        .mode_i   (mode_q),
        .a_o      (step_a),
        .b_o      (step_b),
        .k_o      (step_k),
        .term_o   (step_term),
        .result_o (step_result)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    mode_d  = mode;
                    k_d     = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (step_term) begin
                    res_d   = step_result;
                    state_d = DONE;
                end else begin
                    a_d   = step_a;
                    b_d   = step_b;
                    k_d   = step_k;
                    cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_SUB;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            res_q   <= res_d;
        end
    end

    // Outputs decode directly from state so reset clears them without a clock.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == CALC) || (state_q == DONE);
    assign gcd_out   = out_valid ? res_q : '0;
    assign iter_out  = out_valid ? cnt_q : '0;

endmodule

// File: doc/gcd_unit.md
GCD_UNIT -- requirements
Module: gcd_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and result width, 4..64.
REQ-002 SHALL have parameter CNT_W, default 8: iteration-counter width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: operand pair offered.
REQ-006 SHALL have port in_ready, output, 1: unit accepts operands.
REQ-007 SHALL have port a_in, input, WIDTH: operand A, unsigned.
REQ-008 SHALL have port b_in, input, WIDTH: operand B, unsigned.
REQ-009 SHALL have port mode, input, 1: 0 = subtractive Euclid, 1 = binary (Stein); sampled with operands.
REQ-010 SHALL have port out_valid, output, 1: result held.
REQ-011 SHALL have port out_ready, input, 1: consumer takes result.
REQ-012 SHALL have port gcd_out, output, WIDTH: GCD result.
REQ-013 SHALL have port iter_out, output, CNT_W: step count for this result.
REQ-014 SHALL have port busy, output, 1: high in CALC and DONE.

Function
REQ-015 SHALL implement FSM IDLE, CALC, DONE; in_ready = (state==IDLE), out_valid = (state==DONE).
REQ-016 In IDLE, in_valid&&in_ready SHALL latch a_in, b_in, mode, clear iteration counter and shift count k, and move to CALC.
REQ-017 Each CALC cycle SHALL either perform exactly one step (counter +1, saturating at all-ones) or terminate (no increment) and move to DONE.
REQ-018 Subtractive termination: A==0, B==0, or A==B; result = (A==0) ? B : A.
REQ-019 Subtractive step: A>B -> A<=A-B; else B<=B-A.
REQ-020 Binary termination: A==0 -> B<<k; B==0 -> A<<k; A==B -> A<<k.
REQ-021 Binary step priority: both even -> both >>1, k+1; A even -> A>>1; B even -> B>>1; both odd -> larger <= larger-smaller.
REQ-022 k SHALL be clog2(WIDTH)+1 bits; result shift SHALL never overflow WIDTH.
REQ-023 gcd(0,0) SHALL be 0; gcd(0,x)=gcd(x,0)=x, all with iter_out=0, in both modes.
REQ-024 out_valid SHALL rise the cycle after the terminating CALC cycle; gcd_out, iter_out SHALL hold stable while out_valid&&!out_ready.
REQ-025 out_valid&&out_ready SHALL return to IDLE next cycle; in_ready SHALL rise that cycle (no same-cycle result/accept overlap).
REQ-026 in_valid while busy SHALL be ignored with no state change.
REQ-027 gcd_out and iter_out SHALL read 0 outside DONE.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, A, B, k, counter to 0; out_valid=0, busy=0, gcd_out=0, iter_out=0, in_ready=1.
REQ-029 Reset mid-CALC or mid-DONE SHALL discard the operation; no result is emitted after release.

Structure
REQ-030 Package gcd_pkg SHALL hold the FSM state typedef (IDLE=0, CALC=1, DONE=2) and mode constants MODE_SUB=0, MODE_BIN=1.
REQ-031 One combinational sub-module gcd_step SHALL compute next A, B, k, terminate flag and result from current A, B, k, mode.

Verification
REQ-032 Mode 0, A=143, B=78 -> gcd_out=13, iter_out=6.
REQ-033 Mode 1, A=48, B=18 -> gcd_out=6, iter_out=6; mode 1, A=0, B=35 -> gcd_out=35, iter_out=0; A=B=0 -> 0, 0.
REQ-034 Mode 0, A=1000, B=1, CNT_W=8 -> gcd_out=1, iter_out=255 (saturated).
REQ-035 Backpressure: hold out_ready=0 for 10 cycles, pulse in_valid -> outputs stable, in_ready=0, second operand pair not taken; release -> IDLE next cycle.
REQ-036 Mode 0, A=65535, B=1; drop rst_n for 1 cycle mid-CALC -> all outputs at reset values, in_ready=1, no out_valid until a new operand pair is accepted.
